core_data_mem_responder: RTL
============================

# core_data_mem_responder

Responder (slave) end of the cluster core data protocol: accepts `core_data_req_t` requests, returns `core_data_rsp_t` grants and in-order read/write responses from a local word-addressed memory with configurable wait states and response latency. Serves as the memory-side model behind core data ports and periph-interconnect slave plugs, e.g. as a scratch region or a stand-in for TCDM banks in cluster-level benches.

## Interface
- `BaseAddr`, 32'h1000_0000: byte base address of the served window.
- `MemWords`, 256: memory depth in 32-bit words; power of two, 16..4096.
- `WaitStates`, 0: cycles a request is held with `gnt` low before it is granted; 0..15.
- `Latency`, 1: cycles from grant edge to `r_valid`; 1..4.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `req_i`  in  `core_data_req_t`  request: req, add, we, data, be.
- `rsp_o`  out  `core_data_rsp_t`  response: gnt, r_data, r_valid.
- `stall_i`  in  1  forces `gnt` low while high; does not affect in-flight responses.
- `err_cnt_o`  out  8  saturating count of granted out-of-window accesses.
- `busy_o`  out  1  high while any response is in flight or a request is waiting.

## Operation
- Handshake: transfer accepted on a cycle with `req && gnt`. Initiator holds `req`, `add`, `we`, `data`, `be` stable while `req && !gnt`; responder behaviour under violation is undefined and flagged by bench assertion.
- `gnt` is combinational: `req && !stall_i && (wait_cnt == WaitStates)`.
- Wait FSM, two states. IDLE: `wait_cnt=0`; on `req` with `WaitStates>0` and no grant go to WAIT. WAIT: `wait_cnt` increments each cycle with `req` high and `stall_i` low, saturating at `WaitStates`; on grant return to IDLE, `wait_cnt=0`. `req` dropping in WAIT returns to IDLE, `wait_cnt=0`. `WaitStates=0` never enters WAIT.
- Window hit: `BaseAddr <= add < BaseAddr + 4*MemWords`; word index `add[2+$clog2(MemWords)-1:2]`; `add[1:0]` ignored.
- Write hit: bytes with `be[i]=1` updated at the grant edge; response `r_data=0`.
- Read hit: word sampled at grant edge, including any write granted on the previous cycle (read-after-write coherent).
- Miss: write dropped; read returns `ErrRdata` (32'hBADA_CCE5); `err_cnt_o` increments, saturating at 255.
- Every granted transfer, read or write, produces exactly one `r_valid` pulse; responses in grant order. No response backpressure.
- Back-to-back grants every cycle sustained at full throughput; at most `Latency` transfers in flight.

## Timing
- Reset (`rst_ni` low at a clock edge): response pipeline, wait FSM, `err_cnt_o` cleared; in-flight responses discarded (no `r_valid`). While `rst_ni` low: `gnt=0`, `r_valid=0`, `r_data=0`, `busy_o=0`, `err_cnt_o=0`. Memory contents not reset.
- Grant at edge N -> `r_valid` high in cycle N+`Latency` for one cycle, `r_data` valid in that cycle; `r_data=0` when `r_valid` low.
- First grant after request: `WaitStates` cycles after `req` rises, plus any `stall_i` cycles.
- `stall_i` in WAIT freezes `wait_cnt`.
- `busy_o = req || any pipeline stage valid`.

## Structure
- Reuse `core_data_req_t`/`core_data_rsp_t` from `pulp_cluster_package`; add `ErrRdata` localparam there.
- Sub-module `core_data_resp_pipe`: `Latency`-deep shift register carrying {valid, rdata}, synchronous active-low clear; top holds FSM, memory array, window decode, error counter.

## Test plan
- Latency=1, WaitStates=0: write 0xDEADBEEF be=4'hF to BaseAddr+8, read next cycle -> gnt both cycles, r_valid at N+1, N+2, second r_data=0xDEADBEEF.
- be=4'b0101 write 0x11223344 over 0xAAAAAAAA -> readback 0xAA22AA44.
- WaitStates=3, Latency=2: hold req -> gnt 3 cycles after req rises; r_valid 2 cycles after grant; stall_i high 2 cycles during WAIT -> grant delayed by 2.
- Read BaseAddr+4*MemWords -> r_data 0xBADACCE5, err_cnt_o=1; 300 misses -> err_cnt_o=255; miss write leaves memory unchanged.
- Latency=4, 8 back-to-back reads of distinct preloaded words -> 8 consecutive r_valid cycles, data in order.
- Reset asserted with 3 responses in flight -> no r_valid afterwards, all outputs 0, earlier written data still readable.

Source files
------------

// File: rtl/pulp_cluster_package.sv
// pulp_cluster_package: cluster core data protocol types shared by initiators and responders.
package pulp_cluster_package;
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;
  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;
  localparam logic [31:0] ErrRdata = 32'hBADA_CCE5;
endpackage

// File: rtl/core_data_resp_pipe.sv
// core_data_resp_pipe: fixed-depth shift register carrying {valid, rdata} from grant to response.
module core_data_resp_pipe #(
  parameter int Latency = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        any_valid
);
  logic [Latency-1:0] valid;
  logic [31:0]        rdata [Latency];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < Latency; i++) rdata[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      rdata[0] <= in_rdata;
      for (int i = 1; i < Latency; i++) begin
        valid[i] <= valid[i-1];
        rdata[i] <= rdata[i-1];
      end
    end
  end
  assign out_valid = valid[Latency-1];
  assign out_rdata = rdata[Latency-1];
  assign any_valid = |valid;
endmodule

// File: rtl/core_data_mem_responder.sv
// core_data_mem_responder: word-addressed memory responder with wait states and fixed response latency.
module core_data_mem_responder
  import pulp_cluster_package::*;
#(
  parameter logic [31:0] BaseAddr   = 32'h1000_0000,
  parameter int          MemWords   = 256,
  parameter int          WaitStates = 0,
  parameter int          Latency    = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  core_data_req_t req_i,
  output core_data_rsp_t rsp_o,
  input  logic           stall_i,
  output logic [7:0]     err_cnt_o,
  output logic           busy_o
);
  localparam int         Aw    = $clog2(MemWords);
  localparam logic [32:0] Limit = {1'b0, BaseAddr} + 33'(4 * MemWords);
  localparam logic [0:0] Idle  = 1'b0;
  localparam logic [0:0] Wait  = 1'b1;
  logic [0:0]    state;
  logic [3:0]    wait_cnt;
  logic [7:0]    err_cnt;
  logic [31:0]   mem [MemWords];
  logic          gnt, hit, pipe_valid, pipe_busy;
  logic [31:0]   rdata, pipe_rdata;
  logic [Aw-1:0] idx;
  assign hit   = req_i.add >= BaseAddr && {1'b0, req_i.add} < Limit;
  assign idx   = req_i.add[Aw+1:2];
  assign gnt   = rst_ni && req_i.req && !stall_i && wait_cnt == 4'(WaitStates);
  // Write responses carry zero data; misses read back the error pattern.
  assign rdata = req_i.we ? '0 : hit ? mem[idx] : ErrRdata;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || gnt || !req_i.req) begin
      state    <= Idle;
      wait_cnt <= '0;
    end else begin
      state    <= WaitStates > 0 ? Wait : Idle;
      wait_cnt <= (state == Wait ? wait_cnt : '0) + 4'(!stall_i && wait_cnt != 4'(WaitStates));
    end
  end
  always_ff @(posedge clk_i) begin
    if (gnt && req_i.we && hit)
      for (int i = 0; i < 4; i++)
        if (req_i.be[i]) mem[idx][8*i +: 8] <= req_i.data[8*i +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_cnt <= '0;
    else if (gnt && !hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
  core_data_resp_pipe #(.Latency(Latency)) u_pipe (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .in_valid (gnt),
    .in_rdata (rdata),
    .out_valid(pipe_valid),
    .out_rdata(pipe_rdata),
    .any_valid(pipe_busy)
  );
  assign rsp_o.gnt     = gnt;
  assign rsp_o.r_valid = rst_ni && pipe_valid;
  assign rsp_o.r_data  = rsp_o.r_valid ? pipe_rdata : '0;
  assign err_cnt_o     = rst_ni ? err_cnt : '0;
  assign busy_o        = rst_ni && (req_i.req || pipe_busy);
endmodule
